// File: rtl/set_bit_pkg.sv
// set_bit_pkg: shared definitions for the set_bit flag register.
//   op_t          2-bit command opcode type
//   OP_SET        set one flag bit selected by cmd_idx
//   OP_CLR        clear one flag bit selected by cmd_idx
//   OP_TGL        invert one flag bit selected by cmd_idx
//   OP_WRITE_ALL  load the whole flag vector from cmd_data
package set_bit_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_SET       = 2'd0;
  localparam op_t OP_CLR       = 2'd1;
  localparam op_t OP_TGL       = 2'd2;
  localparam op_t OP_WRITE_ALL = 2'd3;

  // True for the opcodes that address a single bit through cmd_idx.
  function automatic logic op_is_indexed(input op_t op);
    return (op != OP_WRITE_ALL);
  endfunction

endpackage

// File: rtl/set_bit_scan.sv
// set_bit_scan: combinational summary of a flag vector.
//   vec        input  WIDTH   vector to summarise
//   count      output CNT_W   number of set bits
//   first_idx  output IDX_W   index of the lowest set bit, 0 when none set
//   any_set    output 1       OR reduction of vec
module set_bit_scan #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] first_idx,
  output logic             any_set
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + {{(CNT_W-1){1'b0}}, vec[i]};
    end
  end

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    first_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  assign any_set = |vec;

endmodule

// File: rtl/set_bit.sv
// set_bit: constant-1 tie-high source plus a programmable WIDTH-bit flag
// register with status summaries.
//   clk        input  1      rising-edge clock for all state
//   rst        input  1      synchronous active-high reset
//   salida     output 1      hard logic 1, independent of every input
//   cmd_valid  input  1      command strobe, one command per cycle
//   cmd_op     input  2      SET / CLR / TGL / WRITE_ALL
//   cmd_idx    input  IDX_W  bit index for SET / CLR / TGL
//   cmd_data   input  WIDTH  vector for WRITE_ALL
//   flags      output WIDTH  current flag register
//   any_set    output 1      OR of flags
//   all_set    output 1      AND of flags
//   count      output CNT_W  number of set flags
//   first_idx  output IDX_W  lowest set flag index, 0 when none
//   cmd_err    output 1      pulse: previous command had an out-of-range index
module set_bit
  import set_bit_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         salida,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(WIDTH)-1:0]     cmd_idx,
  input  logic [WIDTH-1:0]             cmd_data,
  output logic [WIDTH-1:0]             flags,
  output logic                         any_set,
  output logic                         all_set,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic [$clog2(WIDTH)-1:0]     first_idx,
  output logic                         cmd_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] flags_p0;
  logic [WIDTH-1:0] flags_nxt;
  logic [WIDTH-1:0] bit_mask;
  logic             err_p0;
  logic             err_nxt;
  logic             idx_ok;
  op_t              op;

  // A pure continuous tie: no dependency on clock, reset or any input, so
  // it is valid from time zero.
  assign salida = 1'b1;

  assign op = op_t'(cmd_op);

  // Only reachable as false when WIDTH is not a power of two.
  assign idx_ok = ({{(32-IDX_W){1'b0}}, cmd_idx} < 32'(WIDTH));

  // A shift past the top yields an all-zero mask, so an out-of-range
  // index can never disturb the register even before idx_ok gates it.
  assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << cmd_idx;

  always_comb begin
    flags_nxt = flags_p0;
    err_nxt   = 1'b0;
    if (cmd_valid) begin
      if (op_is_indexed(op) && !idx_ok) begin
        err_nxt = 1'b1;
      end else begin
        case (op)
          OP_SET:       flags_nxt = flags_p0 | bit_mask;
          OP_CLR:       flags_nxt = flags_p0 & ~bit_mask;
          OP_TGL:       flags_nxt = flags_p0 ^ bit_mask;
          OP_WRITE_ALL: flags_nxt = cmd_data;
          default:      flags_nxt = flags_p0;
        endcase
      end
    end
  end

  // Stage p0: flag register and error pulse; reset overrides any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_p0 <= INIT;
      err_p0   <= 1'b0;
    end else begin
      flags_p0 <= flags_nxt;
      err_p0   <= err_nxt;
    end
  end

  assign flags   = flags_p0;
  assign cmd_err = err_p0;
  assign all_set = &flags_p0;

  set_bit_scan #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_scan (
    .vec       (flags_p0),
    .count     (count),
    .first_idx (first_idx),
    .any_set   (any_set)
  );

endmodule

// File: tb/tb_set_bit.sv
// Self-checking bench: a WIDTH=8 and a WIDTH=6 instance see the same
// command stream; expected register state is queued at drive time and
// compared after the capturing edge.
module tb_set_bit;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_idx;
  logic [7:0] cmd_data;

  logic       salida8, any8, all8, err8;
  logic [7:0] flags8;
  logic [3:0] count8;
  logic [2:0] first8;

  logic       salida6, any6, all6, err6;
  logic [5:0] flags6;
  logic [2:0] count6;
  logic [2:0] first6;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] f8;
    logic       e8;
    logic [5:0] f6;
    logic       e6;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m8;
  logic [5:0] m6;

  set_bit #(.WIDTH(8), .INIT(8'h00)) u8 (
    .clk(clk), .rst(rst), .salida(salida8), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .flags(flags8), .any_set(any8), .all_set(all8), .count(count8),
    .first_idx(first8), .cmd_err(err8)
  );

  set_bit #(.WIDTH(6), .INIT(6'h00)) u6 (
    .clk(clk), .rst(rst), .salida(salida6), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data[5:0]),
    .flags(flags6), .any_set(any6), .all_set(all6), .count(count6),
    .first_idx(first6), .cmd_err(err6)
  );

  // Clock held idle until after the tie-high checks at t=10 and t=20.
  initial begin
    clk = 1'b0;
    #25;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] step(input logic [7:0] f, input int w, input logic r,
                                      input logic v, input logic [1:0] op,
                                      input logic [2:0] idx, input logic [7:0] d);
    logic [7:0] wm;
    logic [7:0] nf;
    wm = (w == 8) ? 8'hFF : 8'h3F;
    nf = f;
    if (r) return 9'h000;
    if (!v) return {1'b0, f};
    if (op == 2'd3) return {1'b0, d & wm};
    if (int'(idx) >= w) return {1'b1, f};
    case (op)
      2'd0:    nf[idx] = 1'b1;
      2'd1:    nf[idx] = 1'b0;
      default: nf[idx] = ~nf[idx];
    endcase
    return {1'b0, nf};
  endfunction

  function automatic logic [3:0] popc(input logic [7:0] f);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) if (f[i]) c = c + 4'd1;
    return c;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] f);
    for (int i = 0; i < 8; i++) if (f[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic issue(input logic r, input logic v, input logic [1:0] op,
                       input logic [2:0] idx, input logic [7:0] d);
    logic [8:0] n8;
    logic [8:0] n6;
    exp_t       e;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_idx = idx; cmd_data = d;
    n8 = step(m8, 8, r, v, op, idx, d);
    n6 = step({2'b00, m6}, 6, r, v, op, idx, d);
    m8 = n8[7:0];
    m6 = n6[5:0];
    e.f8 = n8[7:0]; e.e8 = n8[8];
    e.f6 = n6[5:0]; e.e6 = n6[8];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("flags8", flags8, e.f8);
    check("err8",   err8,   e.e8);
    check("any8",   any8,   |e.f8);
    check("all8",   all8,   &e.f8);
    check("count8", count8, popc(e.f8));
    check("first8", first8, lowest(e.f8));
    check("flags6", flags6, e.f6);
    check("err6",   err6,   e.e6);
    check("any6",   any6,   |e.f6);
    check("all6",   all6,   &e.f6);
    check("count6", count6, 3'(popc({2'b00, e.f6})));
    check("first6", first6, lowest({2'b00, e.f6}));
    check("salida8", salida8, 1'b1);
    check("salida6", salida6, 1'b1);
  endtask

  initial begin
    m8 = 8'h00;
    m6 = 6'h00;
    #10;
    check("salida_t10", salida8, 1'b1);
    check("salida6_t10", salida6, 1'b1);
    if (salida8 === 1'b1 && salida6 === 1'b1) $display("Componente OK!");
    #10;
    check("salida_t20", salida8, 1'b1);
    check("salida6_t20", salida6, 1'b1);
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_idx = 3'd0; cmd_data = 8'h00;

    issue(1, 0, 2'd0, 3'd0, 8'h00);
    issue(1, 0, 2'd0, 3'd0, 8'h00);
    check("reset_flags", flags8, 8'h00);
    check("reset_count", count8, 4'd0);

    issue(0, 1, 2'd0, 3'd3, 8'h00);
    check("set3", flags8, 8'h08);
    issue(0, 1, 2'd0, 3'd6, 8'h00);
    check("set6", flags8, 8'h48);
    check("set6_count", count8, 4'd2);
    check("set6_first", first8, 3'd3);
    issue(0, 1, 2'd2, 3'd3, 8'h00);
    check("tgl3", flags8, 8'h40);
    issue(0, 1, 2'd1, 3'd6, 8'h00);
    check("clr6", flags8, 8'h00);
    check("clr6_first", first8, 3'd0);

    issue(0, 1, 2'd3, 3'd7, 8'hFF);
    check("wall_all8", all8, 1'b1);
    check("wall_count8", count8, 4'd8);
    check("wall_all6", all6, 1'b1);
    issue(0, 1, 2'd1, 3'd7, 8'h00);
    check("oor_err6", err6, 1'b1);
    check("oor_flags6", flags6, 6'h3F);
    check("inrange_flags8", flags8, 8'h7F);
    issue(0, 0, 2'd0, 3'd0, 8'h00);
    check("oor_pulse_end", err6, 1'b0);
    issue(0, 1, 2'd2, 3'd6, 8'h00);
    check("oor_tgl_err6", err6, 1'b1);

    issue(1, 1, 2'd3, 3'd0, 8'h55);
    check("rst_wins8", flags8, 8'h00);
    check("rst_wins6", flags6, 6'h00);
    check("rst_err6", err6, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
